// File: rtl/br_lite_local_if.sv
// ---------------------------------------------------------------------------
// br_lite_local_if
//   PE-side adapter on the BR_LOCAL port of the BrLite router.
//   TX path: PE requests are buffered in a small FIFO. Each one is stamped
//   with this PE's seq_source and a wrapping id, then injected using the
//   router's 4-phase local req/ack. A new request is not started while
//   local_busy_i is high.
//   RX path: flits the router delivers locally are accepted into an RX FIFO
//   with a req/ack handshake and handed to the PE over valid/ready.
//
//   Optional build macro: BRLITE_LIF_STATS_EN enables the 16-bit injection
//   and ejection counters on tx_cnt_o / rx_cnt_o. Without it both outputs
//   are tied to zero and no counter flops exist.
//
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   tx_valid_i/tx_ready_o/tx_flit_i   PE request (seq_source, id ignored)
//   local_busy_i                      router local busy
//   inj_flit_o/inj_req_o/inj_ack_i    injection handshake to the router
//   ej_flit_i/ej_req_i/ej_ack_o       ejection handshake from the router
//   rx_valid_o/rx_ready_i/rx_flit_o   RX FIFO head to the PE
//   tx_cnt_o, rx_cnt_o                injection / ejection counters
//
// TX FSM
//   state      | meaning
//   TX_IDLE    | waiting for a queued flit and local_busy_i low
//   TX_REQ     | inj_req_o high, inj_flit_o stable, waiting for ack
//   TX_RELEASE | req dropped, waiting for the router to drop ack
// RX FSM
//   state      | meaning
//   RX_IDLE    | accept ej_flit_i when requested and RX FIFO has room
//   RX_ACK     | ej_ack_o high for one cycle
//   RX_GAP     | ignore ej_req_i for one cycle (stale req from the router)
// ---------------------------------------------------------------------------
package br_lite_pkg;
  localparam int BR_ID_W = 5;

  typedef enum logic [1:0] {
    BR_SVC_ALL = 2'd0,
    BR_SVC_TGT = 2'd1,
    BR_SVC_MON = 2'd2,
    BR_SVC_CLR = 2'd3
  } br_service_t;

  typedef struct packed {
    br_service_t          service;
    logic [15:0]          seq_source;
    logic [BR_ID_W-1:0]   id;
    logic [15:0]          payload;
  } br_data_t;
endpackage

module br_lite_local_if
  import br_lite_pkg::*;
#(
  parameter logic [15:0] SEQ_ADDRESS = 16'h0,
  parameter int unsigned TX_DEPTH    = 2,
  parameter int unsigned RX_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  br_data_t    tx_flit_i,
  input  logic        local_busy_i,
  output br_data_t    inj_flit_o,
  output logic        inj_req_o,
  input  logic        inj_ack_i,
  input  br_data_t    ej_flit_i,
  input  logic        ej_req_i,
  output logic        ej_ack_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output br_data_t    rx_flit_o,
  output logic [15:0] tx_cnt_o,
  output logic [15:0] rx_cnt_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]      TX_PTR_ONE = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]      RX_PTR_ONE = (RX_AW+1)'(1);
  localparam logic [BR_ID_W-1:0]  ID_ONE     = BR_ID_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_RELEASE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GAP}     rx_state_e;

  // ---------------- TX FIFO ----------------
  br_data_t         tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic             tx_empty, tx_full, tx_push, tx_pop;
  br_data_t         tx_head;

  assign tx_empty   = (tx_wr_q == tx_rd_q);
  assign tx_full    = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  // Held low while in reset so the PE never sees a ready FIFO it cannot use.
  assign tx_ready_o = rst_ni && !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign tx_head    = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign tx_wr_d    = tx_push ? tx_wr_q + TX_PTR_ONE : tx_wr_q;
  assign tx_rd_d    = tx_pop  ? tx_rd_q + TX_PTR_ONE : tx_rd_q;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_flit_i;
  end

  // ---------------- TX FSM ----------------
  tx_state_e          tx_state_q, tx_state_d;
  br_data_t           inj_flit_q, inj_flit_d;
  logic [BR_ID_W-1:0] id_cnt_q, id_cnt_d;

  always_comb begin
    tx_state_d = tx_state_q;
    inj_flit_d = inj_flit_q;
    id_cnt_d   = id_cnt_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !local_busy_i) begin
          inj_flit_d            = tx_head;
          inj_flit_d.seq_source = SEQ_ADDRESS;
          inj_flit_d.id         = id_cnt_q;
          tx_state_d            = TX_REQ;
        end
      end
      TX_REQ: begin
        // busy rising here is ignored: a started request always completes
        if (inj_ack_i) begin
          tx_pop     = 1'b1;
          id_cnt_d   = id_cnt_q + ID_ONE;
          tx_state_d = TX_RELEASE;
        end
      end
      TX_RELEASE: begin
        // a 1-cycle ack is already low here, so no hang on short pulses
        if (!inj_ack_i) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      inj_flit_q <= '0;
      id_cnt_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      inj_flit_q <= inj_flit_d;
      id_cnt_q   <= id_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
    end
  end

  assign inj_req_o  = (tx_state_q == TX_REQ);
  assign inj_flit_o = inj_flit_q;

  // ---------------- RX FIFO ----------------
  br_data_t         rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty   = (rx_wr_q == rx_rd_q);
  assign rx_full    = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_valid_o = !rx_empty;
  assign rx_pop     = rx_valid_o && rx_ready_i;
  // Storage is not reset; mask the head so rx_flit_o reads 0 when empty.
  assign rx_flit_o  = rx_empty ? '0 : rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign rx_wr_d    = rx_push ? rx_wr_q + RX_PTR_ONE : rx_wr_q;
  assign rx_rd_d    = rx_pop  ? rx_rd_q + RX_PTR_ONE : rx_rd_q;

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= ej_flit_i;
  end

  // ---------------- RX FSM ----------------
  rx_state_e rx_state_q, rx_state_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (ej_req_i && !rx_full) begin
          rx_push    = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:  rx_state_d = RX_GAP;
      RX_GAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
    end
  end

  assign ej_ack_o = (rx_state_q == RX_ACK);

  // ---------------- statistics ----------------
`ifdef BRLITE_LIF_STATS_EN
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_pop)  tx_cnt_d = tx_cnt_q + 16'd1;
    if (rx_push) rx_cnt_d = rx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_cnt_o = tx_cnt_q;
  assign rx_cnt_o = rx_cnt_q;
`else
  assign tx_cnt_o = '0;
  assign rx_cnt_o = '0;
`endif

endmodule

// File: tb/tb_br_lite_local_if.sv
module tb_br_lite_local_if;
  import br_lite_pkg::*;

  localparam logic [15:0] SEQ = 16'h0005;
  localparam int TXD = 2;
  localparam int RXD = 4;
`ifdef BRLITE_LIF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid_i, tx_ready_o, local_busy_i;
  br_data_t    tx_flit_i, inj_flit_o, ej_flit_i, rx_flit_o;
  logic        inj_req_o, inj_ack_i, ej_req_i, ej_ack_o, rx_valid_o, rx_ready_i;
  logic [15:0] tx_cnt_o, rx_cnt_o;

  always #5 clk = ~clk;

  br_lite_local_if #(.SEQ_ADDRESS(SEQ), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_flit_i(tx_flit_i),
    .local_busy_i(local_busy_i),
    .inj_flit_o(inj_flit_o), .inj_req_o(inj_req_o), .inj_ack_i(inj_ack_i),
    .ej_flit_i(ej_flit_i), .ej_req_i(ej_req_i), .ej_ack_o(ej_ack_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_flit_o(rx_flit_o),
    .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic br_data_t rand_flit();
    br_data_t f;
    f.service    = br_service_t'(2'($urandom_range(3)));
    f.seq_source = 16'($urandom);
    f.id         = BR_ID_W'($urandom);
    f.payload    = 16'($urandom);
    return f;
  endfunction

  // stimulus knobs (percent rates); busy_mode 0=random 1=low 2=high
  int tx_rate = 0, ej_rate = 0, rx_rate = 0, busy_mode = 1;

  // values sampled at the last falling edge (= values seen by the next rising edge)
  logic     s_tx_fire = 0, s_busy = 0, s_inj_req = 0, s_inj_ack = 0;
  logic     s_ej_req = 0, s_ej_ack = 0, s_rx_pop = 0;
  br_data_t s_tx_flit = '0, s_inj_flit = '0, s_ej_flit = '0;

  // ---------------- stimulus: PE and router models ----------------
  int inj_st = 0, inj_wait = 0, inj_hold = 0;
  bit ej_stale = 0;

  initial begin
    tx_valid_i = 0; tx_flit_i = '0; local_busy_i = 0; inj_ack_i = 0;
    ej_req_i = 0; ej_flit_i = '0; rx_ready_i = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        tx_valid_i = 0; local_busy_i = 0; inj_ack_i = 0; ej_req_i = 0; rx_ready_i = 0;
        inj_st = 0; ej_stale = 0;
        continue;
      end
      if (s_tx_fire || !tx_valid_i) begin
        tx_valid_i = (int'($urandom_range(99)) < tx_rate);
        tx_flit_i  = rand_flit();
      end
      case (busy_mode)
        0:       if ($urandom_range(9) == 0) local_busy_i = !local_busy_i;
        1:       local_busy_i = 0;
        default: local_busy_i = 1;
      endcase
      // router injection side: random ack delay, random ack length (1 = pulse)
      case (inj_st)
        0: if (s_inj_req) begin
             inj_wait = int'($urandom_range(3));
             if (inj_wait == 0) begin
               inj_ack_i = 1; inj_hold = int'($urandom_range(1, 4)); inj_st = 2;
             end else inj_st = 1;
           end
        1: begin
             inj_wait--;
             if (inj_wait == 0) begin
               inj_ack_i = 1; inj_hold = int'($urandom_range(1, 4)); inj_st = 2;
             end
           end
        2: begin
             inj_hold--;
             if (inj_hold == 0) begin inj_ack_i = 0; inj_st = 3; end
           end
        default: if (!s_inj_req) inj_st = 0;
      endcase
      // router ejection side: sometimes leaves req up one extra cycle after ack
      if (ej_stale) begin
        ej_stale = 0;
        ej_req_i = 0;
      end else if (!ej_req_i || s_ej_ack) begin
        if (ej_req_i && $urandom_range(1) == 0) ej_stale = 1;
        else begin
          ej_req_i = (int'($urandom_range(99)) < ej_rate);
          if (ej_req_i) ej_flit_i = rand_flit();
        end
      end
      rx_ready_i = (int'($urandom_range(99)) < rx_rate);
    end
  end

  // ---------------- reference model and checks ----------------
  br_data_t           tx_q[$];
  br_data_t           rx_q[$];
  br_data_t           e_flit;
  int                 tx_occ = 0, rx_occ = 0, occ_before = 0;
  int                 cyc = 0, last_acc = -100;
  int                 n_push = 0, n_inj = 0;
  logic [BR_ID_W-1:0] exp_id = '0;
  logic [15:0]        exp_tx_cnt = '0, exp_rx_cnt = '0;
  logic               exp_acc;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tx_q.delete(); rx_q.delete();
      tx_occ = 0; rx_occ = 0; exp_id = '0; exp_tx_cnt = '0; exp_rx_cnt = '0;
      last_acc = cyc - 100; n_push = 0; n_inj = 0;
      s_tx_fire = 0; s_busy = 0; s_inj_req = 0; s_inj_ack = 0;
      s_ej_req = 0; s_ej_ack = 0; s_rx_pop = 0;
      s_tx_flit = '0; s_inj_flit = '0; s_ej_flit = '0;
    end else begin
      // TX: a queued request is injected in order, stamped, one at a time
      occ_before = tx_occ;
      if (s_tx_fire) begin tx_q.push_back(s_tx_flit); tx_occ++; n_push++; end
      if (s_inj_req && s_inj_ack) begin
        if (tx_occ > 0) tx_occ--;
        exp_id++; exp_tx_cnt++; n_inj++;
        chk("req_drop_after_ack", 64'(inj_req_o), 64'(0));
        chk("tx_cnt", 64'(tx_cnt_o), 64'(STATS ? exp_tx_cnt : 16'h0));
      end else if (s_inj_req) begin
        chk("req_held_until_ack", 64'(inj_req_o), 64'(1));
      end
      if (inj_req_o && !s_inj_req) begin
        chk("req_start_not_busy", 64'(s_busy), 64'(0));
        if (occ_before == 0) chk("req_without_prior_push", 64'(inj_req_o), 64'(0));
        if (tx_q.size() > 0) begin
          e_flit = tx_q.pop_front();
          e_flit.seq_source = SEQ;
          e_flit.id = exp_id;
          chk("inj_flit", 64'(inj_flit_o), 64'(e_flit));
        end else chk("req_with_nothing_queued", 64'(inj_req_o), 64'(0));
      end else begin
        chk("inj_flit_hold", 64'(inj_flit_o), 64'(s_inj_flit));
      end
      chk("tx_ready", 64'(tx_ready_o), 64'(tx_occ < TXD));

      // RX: accept when requested, room left, and 3 cycles since last accept
      exp_acc = s_ej_req && (rx_occ < RXD) && ((cyc - last_acc) >= 3);
      chk("ej_ack", 64'(ej_ack_o), 64'(exp_acc));
      if (s_rx_pop && rx_occ > 0) begin void'(rx_q.pop_front()); rx_occ--; end
      if (exp_acc) begin
        rx_q.push_back(s_ej_flit); rx_occ++; last_acc = cyc; exp_rx_cnt++;
        chk("rx_cnt", 64'(rx_cnt_o), 64'(STATS ? exp_rx_cnt : 16'h0));
      end
      chk("rx_valid", 64'(rx_valid_o), 64'(rx_occ > 0));
      if (rx_occ > 0) chk("rx_flit", 64'(rx_flit_o), 64'(rx_q[0]));

      s_tx_fire  = tx_valid_i && tx_ready_o;
      s_tx_flit  = tx_flit_i;
      s_busy     = local_busy_i;
      s_inj_req  = inj_req_o;
      s_inj_ack  = inj_ack_i;
      s_inj_flit = inj_flit_o;
      s_ej_req   = ej_req_i;
      s_ej_flit  = ej_flit_i;
      s_ej_ack   = ej_ack_o;
      s_rx_pop   = rx_valid_o && rx_ready_i;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_inj_req"},  64'(inj_req_o),  64'(0));
    chk({tag, "_ej_ack"},   64'(ej_ack_o),   64'(0));
    chk({tag, "_inj_flit"}, 64'(inj_flit_o), 64'(0));
    chk({tag, "_tx_ready"}, 64'(tx_ready_o), 64'(0));
    chk({tag, "_rx_valid"}, 64'(rx_valid_o), 64'(0));
    chk({tag, "_rx_flit"},  64'(rx_flit_o),  64'(0));
    chk({tag, "_tx_cnt"},   64'(tx_cnt_o),   64'(0));
    chk({tag, "_rx_cnt"},   64'(rx_cnt_o),   64'(0));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 check_all_zero("in_reset");
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk); #1;
    chk("ready_after_reset", 64'(tx_ready_o), 64'(1));

    // mixed random traffic with random busy
    tx_rate = 40; ej_rate = 40; rx_rate = 60; busy_mode = 0;
    repeat (1500) @(posedge clk);

    // busy held high with requests queued, then released
    tx_rate = 100; busy_mode = 2;
    repeat (30) @(posedge clk);
    chk("busy_blocks_tx_ready", 64'(tx_ready_o), 64'(0));
    busy_mode = 1;
    repeat (30) @(posedge clk);

    // RX backpressure: PE stalls while router keeps offering
    tx_rate = 0; ej_rate = 100; rx_rate = 0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    chk("rx_full_valid", 64'(rx_valid_o), 64'(1));
    chk("rx_full_req_pending", 64'(ej_req_i), 64'(1));
    chk("rx_full_no_ack", 64'(ej_ack_o), 64'(0));
    rx_rate = 100;
    repeat (20) @(posedge clk);

    // sustained injection, enough to wrap the id counter several times
    tx_rate = 100; ej_rate = 50; rx_rate = 80; busy_mode = 1;
    repeat (600) @(posedge clk);

    // reset while a request is in flight, then while an ack is up
    ej_rate = 100; rx_rate = 100;
    n = 0;
    @(negedge clk);
    while (!inj_req_o && n < 200) begin @(negedge clk); n++; end
    chk("reached_tx_req", 64'(inj_req_o), 64'(1));
    pulse_reset();
    n = 0;
    @(negedge clk);
    while (!ej_ack_o && n < 200) begin @(negedge clk); n++; end
    chk("reached_rx_ack", 64'(ej_ack_o), 64'(1));
    pulse_reset();

    tx_rate = 40; ej_rate = 40; rx_rate = 60; busy_mode = 0;
    repeat (500) @(posedge clk);

    // drain everything
    tx_rate = 0; ej_rate = 0; rx_rate = 100; busy_mode = 1;
    n = 0;
    while (n < 300 && (tx_occ != 0 || rx_occ != 0 || tx_valid_i || ej_req_i || inj_st != 0)) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk("drain_inj_count", 64'(n_inj), 64'(n_push));
    chk("drain_tx_ready", 64'(tx_ready_o), 64'(1));
    chk("drain_inj_req", 64'(inj_req_o), 64'(0));
    chk("drain_rx_valid", 64'(rx_valid_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
